// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: shared definitions for the bus transfer sequencer.
//  - seqState_t : control-step states (IDLE, T0..T6, DONE, ERR)
//  - SRC_*      : bit positions in the one-hot bus source select
//  - OP_*       : opcode constants and the register-to-register ALU range
//  - oneHot16   : 4-bit register number to 16-bit one-hot
// T6 is only reachable when SEQ_HILO_EN is defined.
package bus_seq_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    DONE = 4'd8,
    ERR  = 4'd9
  } seqState_t;

  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;
  localparam int SRC_Y      = 24;

  localparam logic [4:0] OP_ALU_MIN = 5'b00011;
  localparam logic [4:0] OP_ALU_MAX = 5'b01110;
  localparam logic [4:0] OP_MUL     = 5'b01111;
  localparam logic [4:0] OP_DIV     = 5'b10000;

  function automatic logic [15:0] oneHot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/seq_opcode_decode.sv
// seq_opcode_decode: combinational decode of the instruction register.
// Ports:
//  irValue  in  32  IR contents: [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc
//  legal    out 1   opcode is a register-to-register ALU op (or mul/div when enabled)
//  isHilo   out 1   opcode is mul/div (always 0 unless SEQ_HILO_EN is defined)
//  opcode   out 5   opcode field
//  raOneHot, rbOneHot, rcOneHot  out 16 each  register fields as one-hots
// Macro: SEQ_HILO_EN enables the mul/div opcodes.
module seq_opcode_decode
  import bus_seq_pkg::*;
(
  input  logic [31:0] irValue,
  output logic        legal,
  output logic        isHilo,
  output logic [4:0]  opcode,
  output logic [15:0] raOneHot,
  output logic [15:0] rbOneHot,
  output logic [15:0] rcOneHot
);

  logic aluRange;
  logic unusedIrBits;

  assign opcode   = irValue[31:27];
  assign raOneHot = oneHot16(irValue[26:23]);
  assign rbOneHot = oneHot16(irValue[22:19]);
  assign rcOneHot = oneHot16(irValue[18:15]);
  assign unusedIrBits = ^irValue[14:0];

  assign aluRange = (opcode >= OP_ALU_MIN) && (opcode <= OP_ALU_MAX);

`ifdef SEQ_HILO_EN
  assign isHilo = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
  assign isHilo = 1'b0;
`endif

  assign legal = aluRange || isHilo;

endmodule

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: control-step sequencer for the shared 32-bit datapath bus.
// One instruction per start pulse: fetch T0-T2, execute T3-T5 (T6 for mul/div).
// Outputs are a Moore decode of the state register (plus the IR fields in T3-T5).
// Ports:
//  clock, reset_n (async, active-low), start, ir_value[31:0], mem_ready
//  busy, done, error                 status
//  src_sel[NUM_SRC-1:0]              one-hot bus source select (order in bus_seq_pkg)
//  reg_in[15:0]                      general-register load enables
//  pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in   destination load enables
//  mdr_read, inc_pc, alu_op[4:0]     memory request, PC increment, ALU opcode
// Macro: SEQ_HILO_EN adds mul/div (T5 lo_in, T6 hi_in); otherwise hi_in/lo_in stay 0.
module bus_transfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NUM_SRC     = 25,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        ir_value,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [NUM_SRC-1:0] src_sel,
  output logic [15:0]        reg_in,
  output logic               pc_in,
  output logic               mar_in,
  output logic               ir_in,
  output logic               y_in,
  output logic               z_in,
  output logic               hi_in,
  output logic               lo_in,
  output logic               mdr_read,
  output logic               inc_pc,
  output logic [4:0]         alu_op
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  seqState_t   state, nextState;
  logic [3:0]  waitCnt;
  logic        legal, isHilo;
  logic [4:0]  opcode;
  logic [15:0] raOneHot, rbOneHot, rcOneHot;

  seq_opcode_decode uDecode (
    .irValue  (ir_value),
    .legal    (legal),
    .isHilo   (isHilo),
    .opcode   (opcode),
    .raOneHot (raOneHot),
    .rbOneHot (rbOneHot),
    .rcOneHot (rcOneHot)
  );

`ifndef SEQ_HILO_EN
  logic unusedHilo;
  assign unusedHilo = isHilo;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      // Counts T1 cycles; cleared while fetch begins so each fetch gets a full budget.
      if (state == T1)
        waitCnt <= waitCnt + 4'd1;
      else
        waitCnt <= '0;
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    error     = 1'b0;
    src_sel   = '0;
    reg_in    = '0;
    pc_in     = 1'b0;
    mar_in    = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    mdr_read  = 1'b0;
    inc_pc    = 1'b0;
    alu_op    = '0;

    case (state)
      IDLE: begin
        if (start) nextState = T0;
      end
      T0: begin
        src_sel[SRC_PC] = 1'b1;
        mar_in          = 1'b1;
        inc_pc          = 1'b1;
        z_in            = 1'b1;
        nextState       = T1;
      end
      T1: begin
        src_sel[SRC_ZLO] = 1'b1;
        pc_in            = 1'b1;
        mdr_read         = 1'b1;
        // Data arriving on the last allowed cycle still completes the fetch.
        if (mem_ready)
          nextState = T2;
        else if (waitCnt == TIMEOUT_LAST)
          nextState = ERR;
      end
      T2: begin
        src_sel[SRC_MDR] = 1'b1;
        ir_in            = 1'b1;
        nextState        = T3;
      end
      T3: begin
        if (legal) begin
          src_sel[SRC_R15:SRC_R0] = rbOneHot;
          y_in                    = 1'b1;
          nextState               = T4;
        end else begin
          nextState = ERR;
        end
      end
      T4: begin
        src_sel[SRC_R15:SRC_R0] = rcOneHot;
        alu_op                  = opcode;
        z_in                    = 1'b1;
        nextState               = T5;
      end
      T5: begin
        src_sel[SRC_ZLO] = 1'b1;
`ifdef SEQ_HILO_EN
        if (isHilo) begin
          lo_in     = 1'b1;
          nextState = T6;
        end else begin
          reg_in    = raOneHot;
          nextState = DONE;
        end
`else
        reg_in    = raOneHot;
        nextState = DONE;
`endif
      end
`ifdef SEQ_HILO_EN
      T6: begin
        src_sel[SRC_ZHI] = 1'b1;
        hi_in            = 1'b1;
        nextState        = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      ERR: begin
        error     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Testbench for bus_transfer_sequencer: table of instructions with hand-computed
// outcomes, plus hand-written sequences for the full fetch trace, reset during
// execute and start held high. Expectations follow SEQ_HILO_EN when defined.
module tb_bus_transfer_sequencer;

  logic        clock, reset_n, start, mem_ready;
  logic [31:0] irValue;
  logic        busy, done, error;
  logic [24:0] src_sel;
  logic [15:0] reg_in;
  logic        pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc;
  logic [4:0]  alu_op;

  bus_transfer_sequencer #(.NUM_SRC(25), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ir_value(irValue),
    .mem_ready(mem_ready), .busy(busy), .done(done), .error(error),
    .src_sel(src_sel), .reg_in(reg_in), .pc_in(pc_in), .mar_in(mar_in),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .mdr_read(mdr_read), .inc_pc(inc_pc), .alu_op(alu_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    int          memDelay;
    bit          expDone;
    int          expEnd;
    logic [15:0] expRegIn;
    logic [24:0] expSrcB;
    logic [24:0] expSrcC;
    logic [4:0]  expAlu;
    bit          expHilo;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int testsRun = 0;
  int failures = 0;

  logic [24:0] srcTrace  [0:63];
  logic [8:0]  ctrlTrace [0:63];
  logic [15:0] regTrace  [0:63];
  logic [4:0]  aluTrace  [0:63];
  int          endCycle;
  bit          sawDone, sawErr;
  logic [15:0] regOr;
  logic        idleBusy;

  function automatic logic [31:0] makeIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sampleInv();
    check("srcAtMostOneHot", 64'($countones(src_sel) <= 1), 64'd1);
    if (!busy) check("idleSrcZero", 64'(src_sel), 64'd0);
    check("doneErrorExclusive", 64'(done & error), 64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the pulse cycle.
  task automatic runInstr(input logic [31:0] ir, input int memDelay);
    int waitCnt;
    waitCnt  = 0;
    irValue  = ir;
    start    = 1'b1;
    endCycle = 0;
    sawDone  = 1'b0;
    sawErr   = 1'b0;
    regOr    = '0;
    for (int n = 1; n <= 40 && endCycle == 0; n++) begin
      @(negedge clock);
      start = 1'b0;
      sampleInv();
      srcTrace[n]  = src_sel;
      ctrlTrace[n] = {pc_in, mar_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_read, inc_pc};
      regTrace[n]  = reg_in;
      aluTrace[n]  = alu_op;
      regOr        = regOr | reg_in;
      if (done)  begin sawDone = 1'b1; endCycle = n; end
      if (error) begin sawErr  = 1'b1; endCycle = n; end
      if (mdr_read) begin
        mem_ready = (waitCnt >= memDelay);
        waitCnt++;
      end else begin
        mem_ready = 1'b0;
      end
    end
    @(negedge clock);
    mem_ready = 1'b0;
    sampleInv();
    idleBusy = busy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] expSrc [1:7];
    logic [8:0]  expCtrl[1:7];
    int          doneCnt, idleCnt, d;

    vecs[0] = '{makeIr(5'd3, 4'd3, 4'd1, 4'd2), 0, 1'b1, 7, 16'h0008, 25'h2, 25'h4, 5'd3, 1'b0};
    vecs[1] = '{32'h1988_8000, 0, 1'b1, 7, 16'h0008, 25'h2, 25'h2, 5'd3, 1'b0};
    vecs[2] = '{makeIr(5'd14, 4'd15, 4'd0, 4'd7), 2, 1'b1, 9, 16'h8000, 25'h1, 25'h80, 5'd14, 1'b0};
    vecs[3] = '{makeIr(5'd3, 4'd5, 4'd5, 4'd5), 14, 1'b1, 21, 16'h0020, 25'h20, 25'h20, 5'd3, 1'b0};
    vecs[4] = '{makeIr(5'd3, 4'd1, 4'd2, 4'd3), 15, 1'b0, 17, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};
    vecs[5] = '{makeIr(5'd31, 4'd3, 4'd1, 4'd2), 0, 1'b0, 5, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};
    vecs[6] = '{makeIr(5'd2, 4'd3, 4'd1, 4'd2), 0, 1'b0, 5, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};
`ifdef SEQ_HILO_EN
    vecs[7] = '{makeIr(5'd15, 4'd0, 4'd4, 4'd5), 0, 1'b1, 8, 16'h0, 25'h10, 25'h20, 5'd15, 1'b1};
    vecs[8] = '{makeIr(5'd16, 4'd6, 4'd7, 4'd8), 0, 1'b1, 8, 16'h0, 25'h80, 25'h100, 5'd16, 1'b1};
`else
    vecs[7] = '{makeIr(5'd15, 4'd0, 4'd4, 4'd5), 0, 1'b0, 5, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};
    vecs[8] = '{makeIr(5'd16, 4'd6, 4'd7, 4'd8), 0, 1'b0, 5, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};
`endif
    vecs[9] = '{makeIr(5'd17, 4'd3, 4'd1, 4'd2), 0, 1'b0, 5, 16'h0, 25'h0, 25'h0, 5'd0, 1'b0};

    expSrc  = '{25'h10_0000, 25'h08_0000, 25'h20_0000, 25'h2, 25'h4, 25'h08_0000, 25'h0};
    expCtrl = '{9'b010010001, 9'b100000010, 9'b001000000, 9'b000100000,
                9'b000010000, 9'b000000000, 9'b000000000};

    reset_n   = 1'b0;
    start     = 1'b0;
    irValue   = '0;
    mem_ready = 1'b0;

    // Reset state
    #1;
    check("resetOutputs", {busy, done, error, src_sel, reg_in, pc_in, mar_in, ir_in,
                           y_in, z_in, hi_in, lo_in, mdr_read, inc_pc, alu_op}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("idleAfterReset", 64'(busy), 64'd0);

    // Full trace of add r3,r1,r2
    runInstr(makeIr(5'd3, 4'd3, 4'd1, 4'd2), 0);
    for (int n = 1; n <= 7; n++) begin
      check($sformatf("addSrc[%0d]", n), 64'(srcTrace[n]), 64'(expSrc[n]));
      check($sformatf("addCtrl[%0d]", n), 64'(ctrlTrace[n]), 64'(expCtrl[n]));
    end
    check("addRegInT5", 64'(regTrace[6]), 64'h8);
    check("addAluT4", 64'(aluTrace[5]), 64'd3);
    check("addAluT3", 64'(aluTrace[4]), 64'd0);
    check("addDoneCycle", 64'(endCycle), 64'd7);

    // Instruction table
    for (int i = 0; i < NV; i++) begin
      runInstr(vecs[i].ir, vecs[i].memDelay);
      d = vecs[i].memDelay;
      check($sformatf("v%0d endCycle", i), 64'(endCycle), 64'(vecs[i].expEnd));
      check($sformatf("v%0d done", i), 64'(sawDone), 64'(vecs[i].expDone));
      check($sformatf("v%0d error", i), 64'(sawErr), 64'(!vecs[i].expDone));
      check($sformatf("v%0d regIn", i), 64'(regOr), 64'(vecs[i].expRegIn));
      check($sformatf("v%0d busyAfter", i), 64'(idleBusy), 64'd0);
      if (vecs[i].expDone) begin
        check($sformatf("v%0d srcT3", i), 64'(srcTrace[4+d]), 64'(vecs[i].expSrcB));
        check($sformatf("v%0d srcT4", i), 64'(srcTrace[5+d]), 64'(vecs[i].expSrcC));
        check($sformatf("v%0d aluT4", i), 64'(aluTrace[5+d]), 64'(vecs[i].expAlu));
        check($sformatf("v%0d srcT5", i), 64'(srcTrace[6+d]), 64'h8_0000);
        if (vecs[i].expHilo) begin
          check($sformatf("v%0d loInT5", i), 64'(ctrlTrace[6+d][2]), 64'd1);
          check($sformatf("v%0d hiInT6", i), 64'(ctrlTrace[7+d][3]), 64'd1);
          check($sformatf("v%0d srcT6", i), 64'(srcTrace[7+d]), 64'h4_0000);
        end
      end
    end

    // Reset asserted during T4
    irValue   = makeIr(5'd3, 4'd3, 4'd1, 4'd2);
    mem_ready = 1'b1;
    start     = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      start = 1'b0;
      sampleInv();
    end
    check("midT4AluOp", 64'(alu_op), 64'd3);
    reset_n = 1'b0;
    #1;
    check("midResetOutputs", {busy, done, error, src_sel, reg_in, pc_in, mar_in, ir_in,
                              y_in, z_in, hi_in, lo_in, mdr_read, inc_pc, alu_op}, 64'd0);
    mem_ready = 1'b0;
    @(negedge clock);
    check("heldResetNoPulse", 64'({done, error, busy}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("releaseIdle", 64'({done, error, busy}), 64'd0);
    runInstr(makeIr(5'd3, 4'd3, 4'd1, 4'd2), 0);
    check("postResetDoneCycle", 64'(endCycle), 64'd7);
    check("postResetNoError", 64'(sawErr), 64'd0);

    // Start held high: one instruction per IDLE visit
    irValue   = makeIr(5'd3, 4'd3, 4'd1, 4'd2);
    mem_ready = 1'b1;
    start     = 1'b1;
    doneCnt   = 0;
    idleCnt   = 0;
    for (int n = 1; n <= 23; n++) begin
      @(negedge clock);
      sampleInv();
      if (done) doneCnt++;
      if (!busy) idleCnt++;
      if (n == 8) check("startHeldIdleAt8", 64'(busy), 64'd0);
    end
    start     = 1'b0;
    mem_ready = 1'b0;
    check("startHeldDoneCount", 64'(doneCnt), 64'd3);
    check("startHeldIdleCount", 64'(idleCnt), 64'd2);
    @(negedge clock);
    check("startHeldFinalIdle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
